serial_word_packer: RTL

SERIAL_WORD_PACKER -- requirements
Module: serial_word_packer

---
 rtl/serial_word_packer.sv | 107 ++++++++++
 1 files changed

// File: rtl/serial_word_packer.sv
// Packs an MSB-first serial bit stream into 16-bit words and writes them to a
// downstream FIFO, holding one word while the FIFO is full and counting drops.
module serial_word_packer #(
  parameter int CNT_W = 8
) (
  input  logic             clock_1,
  input  logic             reset,
  input  logic             frame_start,
  input  logic             frame_end,
  input  logic             bit_in,
  input  logic             bit_valid,
  input  logic             buffer_full,
  output logic             data_1_en,
  output logic [15:0]      data_1,
  output logic             pending,
  output logic             in_frame,
  output logic [CNT_W-1:0] ovf_count
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state;
  logic [4:0]  bit_cnt;
  logic [15:0] shift_reg;
  logic [15:0] hold_reg;

  logic        accept;
  logic [4:0]  cnt_base;
  logic [15:0] shift_base;
  logic [15:0] word_next;
  logic        complete;
  logic        release_hold;
  logic        direct_push;

  // A frame_start restarts the word, so the bit sampled with it becomes bit 15.
  assign accept       = bit_valid && (frame_start || (state == SHIFT));
  assign cnt_base     = frame_start ? 5'd0 : bit_cnt;
  assign shift_base   = frame_start ? 16'h0000 : shift_reg;
  assign word_next    = {shift_base[14:0], bit_in};
  assign complete     = accept && (cnt_base == 5'd15);

  // Pushes are only issued when the previous cycle had no strobe, so each push
  // sees the FIFO's updated full flag.
  assign release_hold = pending && !buffer_full && !data_1_en;
  assign direct_push  = complete && !pending && !buffer_full && !data_1_en;

  // NOTE: all state here uses non-blocking assignments so every register samples
  // the pre-edge values computed above, regardless of statement order.
  always_ff @(posedge clock_1 or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_frame  <= 1'b0;
      bit_cnt   <= 5'd0;
      shift_reg <= 16'h0000;
      hold_reg  <= 16'h0000;
      pending   <= 1'b0;
      data_1_en <= 1'b0;
      data_1    <= 16'h0000;
      ovf_count <= '0;
    end else begin
      if (frame_start) begin
        state    <= SHIFT;
        in_frame <= 1'b1;
      end else if (frame_end) begin
        state    <= IDLE;
        in_frame <= 1'b0;
      end

      if (accept) begin
        shift_reg <= word_next;
        bit_cnt   <= complete ? 5'd0 : cnt_base + 5'd1;
      end else if (frame_start) begin
        shift_reg <= 16'h0000;
        bit_cnt   <= 5'd0;
      end

      // A frame end discards any partial word; a word completed by the same bit
      // has already been captured below and the counter is zero anyway.
      if (frame_end && !frame_start) begin
        shift_reg <= 16'h0000;
        bit_cnt   <= 5'd0;
      end

      data_1_en <= release_hold || direct_push;
      if (release_hold)
        data_1 <= hold_reg;
      else if (direct_push)
        data_1 <= word_next;

      if (complete) begin
        if (!pending) begin
          if (!direct_push) begin
            hold_reg <= word_next;
            pending  <= 1'b1;
          end
        end else if (release_hold) begin
          hold_reg <= word_next;
        end else if (ovf_count != {CNT_W{1'b1}}) begin
          ovf_count <= ovf_count + CNT_W'(1);
        end
      end else if (release_hold) begin
        pending <= 1'b0;
      end
    end
  end

endmodule
